// File: rtl/pipe_stage_hs_reg.sv
// Handshaked pipeline stage register carrying a payload plus register-file
// writeback control. SKID=0 is a single register with a combinational ready.
// SKID=1 is a two-slot skid buffer with a registered ready. A forwarding tap
// taken from the head entry feeds the hazard/forwarding unit.
module pipe_stage_hs_reg #(
  parameter int DATA_W = 96,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 3,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_rf_waddr,
  input  logic              in_rf_wena,
  input  logic [SEL_W-1:0]  in_rf_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_rf_waddr,
  output logic              out_rf_wena,
  output logic [SEL_W-1:0]  out_rf_sel,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_waddr,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] waddr;
    logic              wena;
    logic [SEL_W-1:0]  sel;
  } ent_t;

  ent_t in_ent;
  ent_t main_q;
  logic main_v;

  assign in_ent = {in_data, in_rf_waddr, in_rf_wena, in_rf_sel};

  generate
    if (SKID == 0) begin : g_single
      logic in_xfer;
      logic out_xfer;

      assign in_ready  = out_ready | ~main_v;
      assign in_xfer   = in_valid & in_ready;
      assign out_xfer  = main_v & out_ready;
      assign occupancy = {1'b0, main_v};

      // Single holding register: load on accept, empty on drain, else hold.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_q <= '0;
          main_v <= 1'b0;
        end else if (flush) begin
          main_v <= 1'b0;
        end else if (in_xfer) begin
          main_q <= in_ent;
          main_v <= 1'b1;
        end else if (out_xfer) begin
          main_v <= 1'b0;
        end
      end
    end else begin : g_skid
      ent_t skid_q;
      logic skid_v;
      logic rdy_q;
      logic in_xfer;

      // Ready is a flop so upstream never sees a path from out_ready.
      assign in_ready  = rdy_q;
      assign in_xfer   = in_valid & rdy_q;
      assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

      // Main refills from skid first (FIFO order), then from the input;
      // a stalled main diverts an accepted input into skid.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_q <= '0;
          main_v <= 1'b0;
          skid_q <= '0;
          skid_v <= 1'b0;
          rdy_q  <= 1'b1;
        end else if (flush) begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
          rdy_q  <= 1'b1;
        end else if (!main_v || out_ready) begin
          if (skid_v) begin
            main_q <= skid_q;
            main_v <= 1'b1;
            skid_v <= in_xfer;
            rdy_q  <= ~in_xfer;
            if (in_xfer) skid_q <= in_ent;
          end else if (in_xfer) begin
            main_q <= in_ent;
            main_v <= 1'b1;
            rdy_q  <= 1'b1;
          end else begin
            main_v <= 1'b0;
            rdy_q  <= 1'b1;
          end
        end else if (in_xfer) begin
          skid_q <= in_ent;
          skid_v <= 1'b1;
          rdy_q  <= 1'b0;
        end
      end
    end
  endgenerate

  // Head entry drives the outputs; write enables are gated so a stale
  // payload behind a cleared valid can never write back or forward.
  assign out_valid    = main_v;
  assign out_data     = main_q.data;
  assign out_rf_waddr = main_q.waddr;
  assign out_rf_sel   = main_q.sel;
  assign out_rf_wena  = main_q.wena & main_v;
  assign fwd_valid    = out_rf_wena & (main_q.waddr != '0);
  assign fwd_waddr    = main_q.waddr;

endmodule
